// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default widths and
// the Gray/binary conversions used by both the read and write sides.
package fifo_pkg;

   localparam int FIFO_ADDR_W = 5;
   localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;

   // Conversions work on a zero-extended 32-bit word so any pointer width up to 32 fits
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = gray[i] ^ bin[i+1];
      end
      return bin;
   endfunction

endpackage

// File: rtl/r_ptr_empty.sv
// Read-domain pointer and status generator for the async FIFO: advances the
// read pointer on accepted reads and derives empty/almost-empty/fill/underflow.
module r_ptr_empty
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = FIFO_ADDR_W,
   parameter int AE_THRESH = 2
) (
   input  logic            rclk,
   input  logic            rrst_n,
   input  logic            r_en,
   input  logic [ADDR_W:0] g_wptr_sync,
   output logic [ADDR_W:0] b_rptr,
   output logic [ADDR_W:0] g_rptr,
   output logic [ADDR_W-1:0] raddr,
   output logic            empty,
   output logic            almost_empty,
   output logic [ADDR_W:0] r_fill,
   output logic            rd_valid,
   output logic            underflow
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

   logic             accept;
   logic [PTR_W-1:0] b_rptr_next;
   logic [PTR_W-1:0] g_rptr_next;
   logic [PTR_W-1:0] b_wptr_s;
   logic [PTR_W-1:0] fill_next;
   logic             empty_next;
   logic             almost_empty_next;

   // Empty compares against the post-read pointer so reading the last word flags empty on that edge
   always_comb begin
      accept            = r_en & ~empty;
      b_rptr_next       = b_rptr + PTR_W'(accept);
      g_rptr_next       = PTR_W'(bin2gray(32'(b_rptr_next)));
      b_wptr_s          = PTR_W'(gray2bin(32'(g_wptr_sync)));
      empty_next        = (g_rptr_next == g_wptr_sync);
      fill_next         = b_wptr_s - b_rptr_next;
      almost_empty_next = (fill_next <= AE_LIMIT);
   end

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         b_rptr       <= '0;
         g_rptr       <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         r_fill       <= '0;
         rd_valid     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         b_rptr       <= b_rptr_next;
         g_rptr       <= g_rptr_next;
         empty        <= empty_next;
         almost_empty <= almost_empty_next;
         r_fill       <= fill_next;
         rd_valid     <= accept;
         if (r_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   assign raddr = b_rptr[ADDR_W-1:0];

endmodule

// File: doc/r_ptr_empty.md
# r_ptr_empty

Read-side pointer and empty-flag generator for the async FIFO, running entirely in the read clock domain. It accepts read requests and advances a binary read pointer that addresses the FIFO memory. It publishes the Gray-coded read pointer that is synchronized into the write domain for the full flag. It consumes the write-domain Gray pointer after two-flop synchronization and produces registered empty, almost-empty, fill-level and underflow status.

## Interface
- ADDR_W, 5, memory address width; depth = 2**ADDR_W, pointer width PTR_W = ADDR_W+1
- AE_THRESH, 2, almost_empty asserted when fill level ≤ AE_THRESH

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- rclk  in  1  read-domain clock
- rrst_n  in  1  asynchronous active-low reset
- r_en  in  1  read request
- g_wptr_sync  in  PTR_W  Gray write pointer, already 2-flop synchronized into rclk
- b_rptr  out  PTR_W  binary read pointer (registered)
- g_rptr  out  PTR_W  Gray read pointer (registered, sent to write-domain synchronizer)
- raddr  out  ADDR_W  memory read address = b_rptr[ADDR_W-1:0]
- empty  out  1  registered empty flag
- almost_empty  out  1  registered, fill ≤ AE_THRESH
- r_fill  out  PTR_W  registered occupancy as seen by read side (0..2**ADDR_W)
- rd_valid  out  1  pulse one cycle after an accepted read, aligned with registered memory output
- underflow  out  1  sticky, set on read attempt while empty

## Operation
- Accept = r_en & !empty. Only accepted reads advance the pointer.
- b_rptr_next = b_rptr + accept, modulo 2**PTR_W (natural wrap, no skipped codes).
- g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1). b_rptr and g_rptr load on the same edge.
- b_wptr_s = Gray-to-binary of g_wptr_sync (MSB passes through; bit i = g[i] ^ b[i+1]).
- empty_next = (g_rptr_next == g_wptr_sync), full-width compare including MSB.
- fill_next = (b_wptr_s - b_rptr_next) mod 2**PTR_W. Registered into r_fill.
- almost_empty_next = (fill_next ≤ AE_THRESH).
- underflow set when r_en & empty. Cleared only by reset. The pointer does not move on such a cycle.
- rd_valid <= accept.
- Reset values: b_rptr=0, g_rptr=0, empty=1, almost_empty=1, r_fill=0, rd_valid=0, underflow=0.

## Timing
- All outputs are registered. There is no combinational path from r_en or g_wptr_sync to any output.
- An accepted read on edge N gives updated b_rptr/g_rptr/raddr after edge N, and rd_valid=1 for cycle N+1.
- Empty deassertion is pessimistic: a write appears 2 rclk edges (synchronizer) plus 1 edge (this block) after g_wptr changes.
- Empty assertion is immediate: reading the last word sets empty on the same edge that advances the pointer.
- Wrap-around: b_rptr moves from 2**PTR_W-1 to 0, and g_rptr moves from 1 followed by zeros to 0. Empty and fill stay correct across the wrap.
- Simultaneous read of last word and arrival of new g_wptr_sync: empty_next uses the new g_wptr_sync, so empty stays 0 and fill is correct.
- Full FIFO (MSBs differ, lower bits equal): r_fill = 2**ADDR_W and empty = 0.
- Reset mid-operation returns all outputs to reset values asynchronously. Deassertion is synchronized externally to rclk.

## Structure
- Shared package fifo_pkg: PTR_W/ADDR_W localparams, bin2gray and gray2bin functions. The write-pointer block reuses the same functions.
- One natural sub-module is sync_2ff, the instantiated-width 2-flop synchronizer. It lives outside this block at the FIFO top, and this block takes its output.
- Otherwise flat: one always_ff for the state registers and combinational next-state logic.

## Test plan
- Reset with g_wptr_sync=0 -> empty=1, almost_empty=1, r_fill=0, b_rptr=0, g_rptr=0. r_en=1 for 3 cycles -> pointer stays 0, underflow=1.
- g_wptr_sync = gray(3), then r_en held -> empty=0 and r_fill=3 one edge later. Three accepts give b_rptr 1,2,3 and g_rptr 1,3,2. Empty rises on the 3rd accept edge, and rd_valid pulses 3 cycles.
- With AE_THRESH=2, g_wptr_sync=gray(5) -> almost_empty=0. After 3 reads r_fill=2 and almost_empty=1.
- Preload b_rptr near 63 by streaming with g_wptr_sync running ahead. The read at b_rptr=63 gives b_rptr=0 and g_rptr 100000 -> 000000, with no spurious empty while data remains.
- g_wptr_sync = gray(32) with rptr=0 -> r_fill=32, empty=0, almost_empty=0.
- Reset asserted mid-stream with rptr=17 -> all outputs return to reset values without waiting for an rclk edge. underflow clears.
